tft_timing_ctrl: RTL and testbench

TFT_TIMING_CTRL -- requirements
Module: tft_timing_ctrl

---
 rtl/tft_timing_ctrl.sv | 100 ++++++++++
 tb/tb_tft_timing_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tft_timing_ctrl.sv
// TFT panel timing controller.
// A free-running line/frame counter is decoded into a stage-1 pixel request
// (with visible-area coordinates and a frame start pulse). The stage-2 panel
// outputs (syncs, data enable, pixel) follow one clock later. The downstream
// image source answers a request combinationally in the same cycle, so the
// returned pixel lines up with the stage-2 data enable.
module tft_timing_ctrl #(
  parameter int H_Sync         = 128,
  parameter int H_Back_Porch   = 88,
  parameter int H_Visible_area = 800,
  parameter int H_Front_Porch  = 40,
  parameter int V_Sync         = 2,
  parameter int V_Back_Porch   = 33,
  parameter int V_Visible_area = 480,
  parameter int V_Front_Porch  = 10,
  parameter int IMG_DATA_WIDTH = 16
) (
  input  logic                      clk_ctrl,
  input  logic                      reset,
  input  logic [IMG_DATA_WIDTH-1:0] disp_data,
  output logic                      frame_begin,
  output logic                      disp_data_req,
  output logic [11:0]               visible_hcount,
  output logic [11:0]               visible_vcount,
  output logic                      tft_hs,
  output logic                      tft_vs,
  output logic                      tft_de,
  output logic [IMG_DATA_WIDTH-1:0] tft_rgb
);

  // All timing arithmetic is 12-bit unsigned.
  localparam logic [11:0] H_TOTAL  = 12'(H_Sync + H_Back_Porch + H_Visible_area + H_Front_Porch);
  localparam logic [11:0] V_TOTAL  = 12'(V_Sync + V_Back_Porch + V_Visible_area + V_Front_Porch);
  localparam logic [11:0] HS_START = 12'(H_Sync + H_Back_Porch);
  localparam logic [11:0] VS_START = 12'(V_Sync + V_Back_Porch);
  localparam logic [11:0] HS_END   = 12'(H_Sync + H_Back_Porch + H_Visible_area);
  localparam logic [11:0] VS_END   = 12'(V_Sync + V_Back_Porch + V_Visible_area);
  localparam logic [11:0] H_SYNC_W = 12'(H_Sync);
  localparam logic [11:0] V_SYNC_W = 12'(V_Sync);

  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic        h_in_win;
  logic        v_in_win;
  logic        in_win;
  logic        hs_low_p1;
  logic        vs_low_p1;

  // Raster position: hcnt every clock, vcnt on the end-of-line cycle.
  always_ff @(posedge clk_ctrl or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 12'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 12'd1) ? 12'd0 : vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  assign h_in_win = (hcnt >= HS_START) && (hcnt < HS_END);
  assign v_in_win = (vcnt >= VS_START) && (vcnt < VS_END);
  assign in_win   = h_in_win && v_in_win;

  // Stage 1: request, visible coordinates, frame start, raw sync flags.
  always_ff @(posedge clk_ctrl or posedge reset) begin
    if (reset) begin
      disp_data_req  <= 1'b0;
      visible_hcount <= '0;
      visible_vcount <= '0;
      frame_begin    <= 1'b0;
      hs_low_p1      <= 1'b0;
      vs_low_p1      <= 1'b0;
    end else begin
      disp_data_req  <= in_win;
      visible_hcount <= in_win ? hcnt - HS_START : 12'd0;
      visible_vcount <= in_win ? vcnt - VS_START : 12'd0;
      frame_begin    <= (hcnt == 12'd0) && (vcnt == 12'd0);
      hs_low_p1      <= hcnt < H_SYNC_W;
      vs_low_p1      <= vcnt < V_SYNC_W;
    end
  end

  // Stage 2: panel-facing syncs, data enable and pixel (blank outside DE).
  always_ff @(posedge clk_ctrl or posedge reset) begin
    if (reset) begin
      tft_hs  <= 1'b1;
      tft_vs  <= 1'b1;
      tft_de  <= 1'b0;
      tft_rgb <= '0;
    end else begin
      tft_hs  <= ~hs_low_p1;
      tft_vs  <= ~vs_low_p1;
      tft_de  <= disp_data_req;
      tft_rgb <= disp_data_req ? disp_data : '0;
    end
  end

endmodule

// File: tb/tb_tft_timing_ctrl.sv
// Bench for tft_timing_ctrl using a reduced raster so several frames fit in
// a short run. Expected outputs come from the raster position implied by the
// number of clock edges since reset release.
module tb_tft_timing_ctrl;

  localparam int HSY = 4, HBP = 3, HVA = 10, HFP = 2;
  localparam int VSY = 2, VBP = 2, VVA = 5,  VFP = 1;
  localparam int HT  = HSY + HBP + HVA + HFP;   // 19
  localparam int VT  = VSY + VBP + VVA + VFP;   // 10
  localparam int DW  = 16;

  logic          clk_ctrl = 1'b0;
  logic          reset    = 1'b1;
  logic [DW-1:0] disp_data = '0;
  logic          frame_begin, disp_data_req, tft_hs, tft_vs, tft_de;
  logic [11:0]   visible_hcount, visible_vcount;
  logic [DW-1:0] tft_rgb;

  int tests = 0;
  int fails = 0;

  int            k = 0;          // edges since reset release
  int            mode = 0;       // 0: random pixels, 1: pixel = column
  logic [DW-1:0] prev_data = '0; // pixel presented after edge k-1
  int            fb_seen = 0;

  tft_timing_ctrl #(
    .H_Sync(HSY), .H_Back_Porch(HBP), .H_Visible_area(HVA), .H_Front_Porch(HFP),
    .V_Sync(VSY), .V_Back_Porch(VBP), .V_Visible_area(VVA), .V_Front_Porch(VFP),
    .IMG_DATA_WIDTH(DW)
  ) dut (
    .clk_ctrl(clk_ctrl), .reset(reset), .disp_data(disp_data),
    .frame_begin(frame_begin), .disp_data_req(disp_data_req),
    .visible_hcount(visible_hcount), .visible_vcount(visible_vcount),
    .tft_hs(tft_hs), .tft_vs(tft_vs), .tft_de(tft_de), .tft_rgb(tft_rgb)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode of raster position t (clocks since release); t<0 means still in reset.
  task automatic model(input int t, output bit req, output int hc, output int vc,
                       output bit fb, output bit hs_low, output bit vs_low);
    int h, v;
    req = 0; hc = 0; vc = 0; fb = 0; hs_low = 0; vs_low = 0;
    if (t >= 0) begin
      h = t % HT;
      v = (t / HT) % VT;
      req = (h >= HSY + HBP) && (h < HSY + HBP + HVA) &&
            (v >= VSY + VBP) && (v < VSY + VBP + VVA);
      if (req) begin
        hc = h - (HSY + HBP);
        vc = v - (VSY + VBP);
      end
      fb     = (h == 0) && (v == 0);
      hs_low = h < HSY;
      vs_low = v < VSY;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fb"},  frame_begin,    0);
    chk({tag, "_req"}, disp_data_req,  0);
    chk({tag, "_hc"},  visible_hcount, 0);
    chk({tag, "_vc"},  visible_vcount, 0);
    chk({tag, "_hs"},  tft_hs,         1);
    chk({tag, "_vs"},  tft_vs,         1);
    chk({tag, "_de"},  tft_de,         0);
    chk({tag, "_rgb"}, tft_rgb,        0);
  endtask

  task automatic run_cycles(input int n);
    bit req1, fb1, hsl1, vsl1, req2, fb2, hsl2, vsl2;
    int hc1, vc1, hc2, vc2;
    logic [DW-1:0] nd;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ctrl);
      #1;
      k++;
      model(k - 1, req1, hc1, vc1, fb1, hsl1, vsl1);
      model(k - 2, req2, hc2, vc2, fb2, hsl2, vsl2);
      if (frame_begin === 1'b1) fb_seen++;
      chk("frame_begin",    frame_begin,    fb1);
      chk("disp_data_req",  disp_data_req,  req1);
      chk("visible_hcount", visible_hcount, hc1);
      chk("visible_vcount", visible_vcount, vc1);
      chk("tft_hs",         tft_hs,         !hsl2);
      chk("tft_vs",         tft_vs,         !vsl2);
      chk("tft_de",         tft_de,         req2);
      chk("tft_rgb",        tft_rgb,        req2 ? prev_data : '0);
      // Downstream pixel for the request just issued.
      if (mode == 1)                     nd = DW'(hc1);
      else if ($urandom_range(3) == 0)   nd = '1;
      else                               nd = DW'($urandom);
      disp_data = nd;
      prev_data = nd;
    end
  endtask

  initial begin
    // Held in reset across clock edges.
    reset = 1'b1;
    disp_data = '1;
    repeat (3) @(posedge clk_ctrl);
    #1;
    chk_reset_vals("reset_hold");

    // Release away from the clock edge; edge 1 carries frame_begin.
    @(negedge clk_ctrl);
    reset = 1'b0;
    k = 0; prev_data = '0; fb_seen = 0;
    run_cycles(2 * HT * VT + 6 * HT + 8);
    chk("frame_count_run1", fb_seen, 3);

    // Asynchronous reset mid-line, between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    repeat (2) @(posedge clk_ctrl);
    #1;
    chk_reset_vals("async_reset_hold");

    // Restart from (0,0) with pixel = column index.
    @(negedge clk_ctrl);
    reset = 1'b0;
    k = 0; prev_data = '0; fb_seen = 0;
    mode = 1;
    run_cycles(2 * HT * VT + 3);
    chk("frame_count_run2", fb_seen, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
